// File: rtl/match_count_accumulator.sv
// match_count_accumulator
//   Collects per-state match counts for two character streams and reads them
//   back in hardware. Each accept pulse performs a read-modify-write on an
//   internal counter RAM. On request the non-zero entries stream out over a
//   valid/ready interface. After the dump the RAM is cleared for the next run.
//
// Ports
//   tb_clk          clock, rising edge
//   reset           synchronous, active-low
//   size            active entry count, sampled on reset release and on CLEAR entry
//   match_flag      stream-1 accept pulse
//   match_flag_2    stream-2 accept pulse
//   match_idx       state index qualifying either flag
//   dump_req        starts a readout (RUN only)
//   dump_valid      dump entry valid
//   dump_ready      consumer accepts entry on valid && ready
//   dump_idx        index of dumped entry
//   dump_cnt        stream-1 count of entry
//   dump_cnt_2      stream-2 count of entry
//   dump_done       one-cycle pulse when readout completes
//   busy            high outside RUN
//   drop_count      saturating count of in-range event cycles arriving while busy
//   total_matches   wrapping count of flags accepted in RUN
module match_count_accumulator #(
    parameter int unsigned size_range = 2794,
    parameter int unsigned IDX_W      = 20,
    parameter int unsigned CNT_W      = 10
) (
    input  logic              tb_clk,
    input  logic              reset,
    input  logic [23:0]       size,
    input  logic              match_flag,
    input  logic              match_flag_2,
    input  logic [IDX_W-1:0]  match_idx,
    input  logic              dump_req,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [IDX_W-1:0]  dump_idx,
    output logic [CNT_W-1:0]  dump_cnt,
    output logic [CNT_W-1:0]  dump_cnt_2,
    output logic              dump_done,
    output logic              busy,
    output logic [15:0]       drop_count,
    output logic [31:0]       total_matches
);

    localparam int unsigned AW = (size_range > 1) ? $clog2(size_range) : 1;
    localparam int unsigned DW = 2 * CNT_W;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DUMP_RD,
        S_DUMP_CHK,
        S_DUMP_OUT,
        S_FINISH
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_ptr;
    logic [23:0]       r_size;
    logic              r_drain_ph;

    // Word layout: {stream-2 count, stream-1 count}
    logic [DW-1:0]     r_mem [0:size_range-1];
    logic [DW-1:0]     r_rd_data;

    logic              r_s1_valid;
    logic              r_s1_f1;
    logic              r_s1_f2;
    logic [AW-1:0]     r_s1_addr;
    logic              r_byp_valid;
    logic [DW-1:0]     r_byp_data;

    logic [IDX_W-1:0]  r_dump_idx;
    logic [CNT_W-1:0]  r_dump_cnt;
    logic [CNT_W-1:0]  r_dump_cnt_2;
    logic [15:0]       r_drop;
    logic [31:0]       r_total;

    logic [23:0]       w_size_eff;
    logic              w_in_range;
    logic              w_ev;
    logic              w_accept;
    logic              w_last;
    logic [AW-1:0]     w_rd_addr;
    logic [DW-1:0]     w_s1_old;
    logic [DW-1:0]     w_s1_new;
    logic              w_we;
    logic [AW-1:0]     w_wr_addr;
    logic [DW-1:0]     w_wr_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Requests larger than the RAM are limited to its depth.
    assign w_size_eff = (32'(size) > size_range) ? 24'(size_range) : size;

    assign w_in_range = (32'(match_idx) < 32'(r_size));
    assign w_ev       = (match_flag | match_flag_2) & w_in_range;
    assign w_accept   = (r_state == S_RUN) & w_ev;
    assign w_last     = ((32'(r_ptr) + 32'd1) == 32'(r_size));

    // In RUN the read port follows the incoming index (pipeline S0);
    // otherwise it follows the sweep pointer.
    assign w_rd_addr = (r_state == S_RUN) ? match_idx[AW-1:0] : r_ptr;

    // A back-to-back hit on the same index reads stale RAM data because the
    // older write lands on the same edge as the read; forward that write instead.
    assign w_s1_old = r_byp_valid ? r_byp_data : r_rd_data;
    assign w_s1_new = {sat_inc(w_s1_old[DW-1:CNT_W], r_s1_f2),
                       sat_inc(w_s1_old[CNT_W-1:0], r_s1_f1)};

    assign w_we      = reset & ((r_state == S_CLEAR) | r_s1_valid);
    assign w_wr_addr = (r_state == S_CLEAR) ? r_ptr : r_s1_addr;
    assign w_wr_data = (r_state == S_CLEAR) ? '0 : w_s1_new;

    // Read returns the pre-write contents when addresses collide.
    always_ff @(posedge tb_clk) begin
        if (w_we) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: begin
                if ((r_size == '0) || w_last) w_next = S_RUN;
            end
            S_RUN: begin
                if (dump_req) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain_ph) w_next = (r_size == '0) ? S_FINISH : S_DUMP_RD;
            end
            S_DUMP_RD: begin
                w_next = S_DUMP_CHK;
            end
            S_DUMP_CHK: begin
                if (r_rd_data != '0) w_next = S_DUMP_OUT;
                else if (w_last)     w_next = S_FINISH;
                else                 w_next = S_DUMP_RD;
            end
            S_DUMP_OUT: begin
                if (dump_ready) w_next = w_last ? S_FINISH : S_DUMP_RD;
            end
            S_FINISH: begin
                w_next = S_CLEAR;
            end
            default: w_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge tb_clk) begin
        if (!reset) begin
            r_state      <= S_CLEAR;
            r_ptr        <= '0;
            r_size       <= w_size_eff;
            r_drain_ph   <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_f1      <= 1'b0;
            r_s1_f2      <= 1'b0;
            r_s1_addr    <= '0;
            r_byp_valid  <= 1'b0;
            r_byp_data   <= '0;
            r_dump_idx   <= '0;
            r_dump_cnt   <= '0;
            r_dump_cnt_2 <= '0;
            r_drop       <= '0;
            r_total      <= '0;
        end else begin
            r_state <= w_next;

            case (r_state)
                S_CLEAR: begin
                    r_ptr <= (w_next == S_RUN) ? '0 : r_ptr + AW'(1);
                end
                S_RUN: begin
                    r_ptr <= '0;
                end
                S_DRAIN: begin
                    r_drain_ph <= ~r_drain_ph;
                    r_ptr      <= '0;
                end
                S_DUMP_CHK: begin
                    if (r_rd_data != '0) begin
                        r_dump_idx   <= IDX_W'(r_ptr);
                        r_dump_cnt   <= r_rd_data[CNT_W-1:0];
                        r_dump_cnt_2 <= r_rd_data[DW-1:CNT_W];
                    end else if (!w_last) begin
                        r_ptr <= r_ptr + AW'(1);
                    end
                end
                S_DUMP_OUT: begin
                    if (dump_ready && !w_last) r_ptr <= r_ptr + AW'(1);
                end
                S_FINISH: begin
                    r_ptr  <= '0;
                    r_size <= w_size_eff;
                end
                default: ;
            endcase

            r_s1_valid  <= w_accept;
            r_s1_f1     <= match_flag;
            r_s1_f2     <= match_flag_2;
            r_s1_addr   <= match_idx[AW-1:0];
            r_byp_valid <= w_accept & r_s1_valid & (match_idx[AW-1:0] == r_s1_addr);
            r_byp_data  <= w_s1_new;

            if (w_accept) begin
                r_total <= r_total + 32'(match_flag) + 32'(match_flag_2);
            end
            if ((r_state != S_RUN) && w_ev && (r_drop != '1)) begin
                r_drop <= r_drop + 16'd1;
            end
        end
    end

    assign dump_valid    = (r_state == S_DUMP_OUT);
    assign dump_done     = (r_state == S_FINISH);
    assign busy          = (r_state != S_RUN);
    assign dump_idx      = r_dump_idx;
    assign dump_cnt      = r_dump_cnt;
    assign dump_cnt_2    = r_dump_cnt_2;
    assign drop_count    = r_drop;
    assign total_matches = r_total;

endmodule

// File: tb/tb_match_count_accumulator.sv
module tb_match_count_accumulator;

    localparam int unsigned SIZE_RANGE = 2794;
    localparam int unsigned IDX_W      = 20;
    localparam int unsigned CNT_W      = 10;
    localparam int unsigned CMAX       = (1 << CNT_W) - 1;

    logic              tb_clk = 1'b0;
    logic              reset;
    logic [23:0]       size;
    logic              match_flag;
    logic              match_flag_2;
    logic [IDX_W-1:0]  match_idx;
    logic              dump_req;
    logic              dump_valid;
    logic              dump_ready;
    logic [IDX_W-1:0]  dump_idx;
    logic [CNT_W-1:0]  dump_cnt;
    logic [CNT_W-1:0]  dump_cnt_2;
    logic              dump_done;
    logic              busy;
    logic [15:0]       drop_count;
    logic [31:0]       total_matches;

    always #5 tb_clk = ~tb_clk;

    match_count_accumulator #(
        .size_range (SIZE_RANGE),
        .IDX_W      (IDX_W),
        .CNT_W      (CNT_W)
    ) dut (
        .tb_clk        (tb_clk),
        .reset         (reset),
        .size          (size),
        .match_flag    (match_flag),
        .match_flag_2  (match_flag_2),
        .match_idx     (match_idx),
        .dump_req      (dump_req),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_idx      (dump_idx),
        .dump_cnt      (dump_cnt),
        .dump_cnt_2    (dump_cnt_2),
        .dump_done     (dump_done),
        .busy          (busy),
        .drop_count    (drop_count),
        .total_matches (total_matches)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: plain per-index counters and running totals.
    int unsigned m_cnt1 [SIZE_RANGE];
    int unsigned m_cnt2 [SIZE_RANGE];
    int unsigned m_size;
    int unsigned m_total;
    int unsigned m_drop;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear_counts();
        for (int unsigned i = 0; i < SIZE_RANGE; i++) begin
            m_cnt1[i] = 0;
            m_cnt2[i] = 0;
        end
    endfunction

    function automatic void model_ev(input bit f1, input bit f2, input int unsigned idx, input bit running);
        if (!(f1 || f2) || idx >= m_size) return;
        if (running) begin
            m_total = m_total + (f1 ? 1 : 0) + (f2 ? 1 : 0);
            if (f1 && m_cnt1[idx] < CMAX) m_cnt1[idx]++;
            if (f2 && m_cnt2[idx] < CMAX) m_cnt2[idx]++;
        end else if (m_drop < 65535) begin
            m_drop++;
        end
    endfunction

    task automatic flags_off();
        match_flag   = 1'b0;
        match_flag_2 = 1'b0;
        match_idx    = '0;
    endtask

    // Drive one cycle of events while the DUT is known to be in RUN.
    task automatic drive_ev(input bit f1, input bit f2, input int unsigned idx);
        match_flag   = f1;
        match_flag_2 = f2;
        match_idx    = IDX_W'(idx);
        model_ev(f1, f2, idx, 1'b1);
        @(negedge tb_clk);
    endtask

    task automatic wait_idle();
        int unsigned cyc = 0;
        while (busy && cyc < 4 * SIZE_RANGE + 64) begin
            @(negedge tb_clk);
            cyc++;
        end
        check_val("idle_reached", {63'b0, busy}, 64'd0);
    endtask

    task automatic do_reset(input int unsigned sz, input int unsigned n_clear_ev);
        int unsigned cyc;
        int unsigned idx;
        bit          saw_done;
        reset     = 1'b0;
        size      = 24'(sz);
        dump_req  = 1'b0;
        dump_ready = 1'b0;
        flags_off();
        @(negedge tb_clk);
        check_val("rst_valid", {63'b0, dump_valid}, 64'd0);
        check_val("rst_done",  {63'b0, dump_done},  64'd0);
        check_val("rst_busy",  {63'b0, busy},       64'd1);
        check_val("rst_drop",  {48'b0, drop_count}, 64'd0);
        check_val("rst_total", {32'b0, total_matches}, 64'd0);
        reset   = 1'b1;
        m_size  = (sz > SIZE_RANGE) ? SIZE_RANGE : sz;
        m_total = 0;
        m_drop  = 0;
        model_clear_counts();
        cyc      = 0;
        saw_done = 1'b0;
        do begin
            if (cyc < n_clear_ev) begin
                idx          = $urandom_range(0, m_size - 1);
                match_flag   = 1'b1;
                match_flag_2 = 1'b0;
                match_idx    = IDX_W'(idx);
                model_ev(1'b1, 1'b0, idx, 1'b0);
            end else begin
                flags_off();
            end
            @(negedge tb_clk);
            cyc++;
            saw_done |= dump_done;
        end while (busy && cyc < m_size + 16);
        flags_off();
        check_val("clear_cycles", 64'(cyc), 64'((m_size == 0) ? 1 : m_size));
        check_val("clear_no_done", {63'b0, saw_done}, 64'd0);
    endtask

    task automatic run_dump(input int unsigned n_busy_ev, input bit same_ev, input bit hold_first);
        int unsigned exp_q[$];
        int unsigned n_exp, cyc, got, held, limit, idx, e;
        bit          done, pend, f2;
        logic [39:0] last_f;

        dump_req = 1'b1;
        if (same_ev) begin
            idx = $urandom_range(0, m_size - 1);
            f2  = 1'($urandom_range(0, 1));
            match_flag   = 1'b1;
            match_flag_2 = f2;
            match_idx    = IDX_W'(idx);
            model_ev(1'b1, f2, idx, 1'b1);
        end else begin
            flags_off();
        end
        @(negedge tb_clk);
        dump_req = 1'b0;
        flags_off();

        for (int unsigned i = 0; i < m_size; i++) begin
            if (m_cnt1[i] != 0 || m_cnt2[i] != 0) exp_q.push_back(i);
        end
        n_exp = exp_q.size();
        limit = 4 * m_size + 64 + 16 * n_exp;
        cyc = 0; got = 0; held = 0; done = 1'b0; pend = 1'b0; last_f = '0;

        while (!done && cyc < limit) begin
            if (pend) begin
                check_val("dump_hold", {23'b0, dump_valid, dump_idx, dump_cnt, dump_cnt_2}, {23'b0, 1'b1, last_f});
            end
            pend = 1'b0;
            if (dump_done) begin
                done = 1'b1;
                break;
            end
            if (cyc < n_busy_ev) begin
                idx          = $urandom_range(0, m_size - 1);
                match_flag   = 1'b1;
                match_flag_2 = 1'b0;
                match_idx    = IDX_W'(idx);
                model_ev(1'b1, 1'b0, idx, 1'b0);
            end else begin
                flags_off();
            end
            if (dump_valid) begin
                if (hold_first && held < 10) begin
                    dump_ready = 1'b0;
                    held++;
                end else begin
                    dump_ready = ($urandom_range(0, 2) != 0);
                end
                if (dump_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("dump_extra", {24'b0, dump_idx, dump_cnt, dump_cnt_2}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("dump_entry", {24'b0, dump_idx, dump_cnt, dump_cnt_2},
                                  {24'b0, IDX_W'(e), CNT_W'(m_cnt1[e]), CNT_W'(m_cnt2[e])});
                    end
                    got++;
                end else begin
                    pend   = 1'b1;
                    last_f = {dump_idx, dump_cnt, dump_cnt_2};
                end
            end else begin
                dump_ready = 1'($urandom_range(0, 1));
            end
            @(negedge tb_clk);
            cyc++;
        end
        dump_ready = 1'b0;
        flags_off();
        check_val("dump_done_seen", {63'b0, done}, 64'd1);
        check_val("dump_count", 64'(got), 64'(n_exp));
        @(negedge tb_clk);
        check_val("done_pulse", {63'b0, dump_done}, 64'd0);
        check_val("total_matches", {32'b0, total_matches}, 64'(m_total));
        check_val("drop_count", {48'b0, drop_count}, 64'(m_drop));
        model_clear_counts();
        wait_idle();
    endtask

    // Starts a dump and resets the DUT while the first entry is presented.
    task automatic dump_abort(input int unsigned sz);
        int unsigned cyc = 0;
        bit          saw_done = 1'b0;
        dump_req = 1'b1;
        flags_off();
        @(negedge tb_clk);
        dump_req   = 1'b0;
        dump_ready = 1'b0;
        while (!dump_valid && cyc < 4 * m_size + 64) begin
            saw_done |= dump_done;
            @(negedge tb_clk);
            cyc++;
        end
        check_val("abort_valid_seen", {63'b0, dump_valid}, 64'd1);
        check_val("abort_no_done", {63'b0, saw_done}, 64'd0);
        do_reset(sz, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned base, idx, sz;
        reset      = 1'b0;
        size       = 24'd2794;
        dump_req   = 1'b0;
        dump_ready = 1'b0;
        flags_off();
        m_size = SIZE_RANGE; m_total = 0; m_drop = 0;
        model_clear_counts();
        @(negedge tb_clk);

        // Full-depth clear with two events dropped during CLEAR, then an empty dump.
        do_reset(2794, 2);
        check_val("drop_after_clear", {48'b0, drop_count}, 64'd2);
        run_dump(0, 1'b0, 1'b0);

        // Directed counts, two events dropped during the dump, ready held low.
        for (int k = 0; k < 3; k++) drive_ev(1'b1, 1'b0, 5);
        drive_ev(1'b1, 1'b1, 7);
        flags_off();
        @(negedge tb_clk);
        check_val("total_directed", {32'b0, total_matches}, 64'd5);
        run_dump(2, 1'b0, 1'b1);
        check_val("drop_directed", {48'b0, drop_count}, 64'd4);

        // Out-of-range index is ignored entirely.
        for (int k = 0; k < 3; k++) drive_ev(1'b1, 1'b1, 3000);
        flags_off();
        repeat (2) @(negedge tb_clk);
        check_val("oor_drop", {48'b0, drop_count}, 64'd4);
        check_val("oor_total", {32'b0, total_matches}, 64'(m_total));

        // Saturation at one index and alternating back-to-back indices.
        for (int k = 0; k < 1100; k++) drive_ev(1'b1, 1'b0, 100);
        for (int k = 0; k < 20; k++) drive_ev(1'b1, 1'b0, (k % 2 == 0) ? 100 : 101);
        flags_off();
        @(negedge tb_clk);
        run_dump(0, 1'b1, 1'b0);

        // Randomized rounds at smaller sizes with local index clusters.
        for (int r = 0; r < 3; r++) begin
            sz = $urandom_range(16, 80);
            do_reset(sz, $urandom_range(0, 3));
            base = 0;
            for (int k = 0; k < 300; k++) begin
                if (k % 20 == 0) base = $urandom_range(0, m_size + 4);
                idx = ($urandom_range(0, 15) == 0) ? $urandom_range(0, (1 << IDX_W) - 1)
                                                   : base + $urandom_range(0, 3);
                if ($urandom_range(0, 3) == 0) drive_ev(1'b0, 1'b0, idx);
                else drive_ev(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), idx);
            end
            flags_off();
            @(negedge tb_clk);
            run_dump($urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
        end

        // Reset during DUMP_OUT aborts the readout; a fresh dump is empty.
        do_reset(100, 0);
        drive_ev(1'b1, 1'b0, 9);
        drive_ev(1'b0, 1'b1, 9);
        flags_off();
        @(negedge tb_clk);
        dump_abort(100);
        run_dump(0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
